bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 15 +
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 87 ++++++++
 tb/tb_bin2bcd_seq.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int W_DEF = 14;
  localparam int D_DEF = 4;

  localparam logic [3:0] DASH = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a requester and bin2bcd_seq.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = W_DEF,
  parameter int DIGITS = D_DEF
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic                  busy;
  logic                  done;

  modport master (
    output start, bin,
    input  bcd, ovf, busy, done
  );

  modport slave (
    input  start, bin,
    output bcd, ovf, busy, done
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one bit per clock, with overflow dashes.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = W_DEF,
  parameter int DIGITS = D_DEF
) (
  input  logic clk,
  input  logic rst_n,
  bin2bcd_seq_if.slave io
);

  localparam int AW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);

  state_t              state;
  state_t              state_n;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_adj;
  logic [WIDTH-1:0]    sr;
  logic [CW-1:0]       cnt;
  logic [AW+WIDTH-1:0] shl;
  logic [4*DIGITS-1:0] bcd_q;
  logic                ovf_q;
  logic                last;
  logic                ovf_n;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (acc[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  assign shl   = {acc_adj, sr} << 1;
  assign last  = (cnt == CW'(1));
  // Top nibble holds the digit above DIGITS; nonzero means out of range.
  assign ovf_n = |shl[WIDTH + 4*DIGITS +: 4];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (io.start) state_n = SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      sr    <= '0;
      cnt   <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (io.start) begin
            sr  <= io.bin;
            acc <= '0;
            cnt <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          {acc, sr} <= shl;
          cnt       <= cnt - CW'(1);
          if (last) begin
            ovf_q <= ovf_n;
            bcd_q <= ovf_n ? {DIGITS{DASH}}
                           : shl[WIDTH +: 4*DIGITS];
          end
        end
        default: ;
      endcase
    end
  end

  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;
  assign io.busy = (state != IDLE);
  assign io.done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Random and directed checks of bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errs  = 0;
  int   checks = 0;

  bin2bcd_seq_if #(.WIDTH(W_DEF), .DIGITS(D_DEF)) io ();

  bin2bcd_seq #(
    .WIDTH  (W_DEF),
    .DIGITS (D_DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(int v);
    logic [15:0] r;
    int x;
    r = '0;
    if (v > 9999) return 16'hFFFF;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic run(input int v, output logic [15:0] b,
                     output logic o, output int lat,
                     output logic stable);
    logic [15:0] held;
    @(negedge clk);
    io.bin   = 14'(v);
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.bin   = 14'($urandom);
    lat      = 1;
    held     = io.bcd;
    stable   = 1'b1;
    while (!io.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!io.done && io.bcd !== held) stable = 1'b0;
    end
    b = io.bcd;
    o = io.ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input int v, input string tag);
    logic [15:0] b;
    logic        o;
    int          lat;
    logic        st;
    string       t;
    t = $sformatf("%s_%0d", tag, v);
    run(v, b, o, lat, st);
    check({t, "_bcd"}, 32'(b), 32'(ref_bcd(v)));
    check({t, "_ovf"}, 32'(o), 32'(v > 9999));
    check({t, "_lat"}, 32'(lat), 32'(W_DEF + 1));
    check({t, "_hold"}, 32'(st), 32'd1);
  endtask

  initial begin
    int          dones;
    logic [15:0] got;

    io.start = 1'b1;
    io.bin   = 14'd77;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd", 32'(io.bcd), 32'd0);
    check("rst_ovf", 32'(io.ovf), 32'd0);
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_done", 32'(io.done), 32'd0);
    @(negedge clk);
    io.start = 1'b0;
    rst_n    = 1'b1;

    conv(0, "zero");
    conv(1234, "mid");
    conv(9999, "max");
    conv(10000, "ovf_lo");
    conv(16383, "ovf_hi");

    // A start pulse in the middle of a conversion must not be queued.
    @(negedge clk);
    io.bin   = 14'd42;
    io.start = 1'b1;
    @(posedge clk);
    dones = 0;
    got   = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      io.start = (i == 4);
      io.bin   = 14'($urandom);
      @(posedge clk);
      #1;
      if (io.done) begin
        dones++;
        got = io.bcd;
      end
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_bcd", 32'(got), 32'h0042);

    @(negedge clk);
    io.bin   = 14'd5678;
    io.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(io.busy), 32'd0);
    check("abort_bcd", 32'(io.bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (io.done) dones++;
    end
    check("abort_dones", 32'(dones), 32'd0);
    conv(5678, "after_rst");

    for (int v = 0; v < 16384; v += 7) conv(v, "sweep");
    conv(16383, "sweep");
    repeat (100) conv(int'($urandom_range(0, 16383)), "rand");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
